mips_run_ctrl: RTL and testbench
================================

# mips_run_ctrl

- Sequences the 16-bit single-cycle MIPS core (`mips_top`).
- Streams a program into instruction memory while holding the core in reset.
- Then gates core execution through a run / halt / single-step state machine, with an optional PC breakpoint.
- Sits between the debug/loader host interface and `mips_top`; `pc` is driven from the core's `pc_out`.

## Interface
Parameters:
- `ADDR_W`, 16, PC and instruction-memory address width
- `DATA_W`, 16, instruction word width
- `CNT_W`, 32, executed-cycle counter width

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `load_valid`  in  1  loader word valid
- `load_ready`  out  1  controller accepts loader word
- `load_addr`  in  ADDR_W  target imem address
- `load_data`  in  DATA_W  instruction word
- `load_last`  in  1  final word of program
- `imem_we`  out  1  instruction-memory write enable
- `imem_waddr`  out  ADDR_W  write address
- `imem_wdata`  out  DATA_W  write data
- `cmd_run`, `cmd_step`, `cmd_halt`, `cmd_load`  in  1 each  host commands, level-sampled each cycle
- `pc`  in  ADDR_W  current core PC (`pc_out`)
- `bp_valid`  in  1  breakpoint armed
- `bp_addr`  in  ADDR_W  breakpoint PC
- `core_rst`  out  1  active-high core reset (integrator inverts to the core's `rst_n`)
- `core_en`  out  1  core commit enable (PC, regfile and dmem writes)
- `halted`  out  1  state == HALTED
- `bp_hit`  out  1  sticky breakpoint-hit flag
- `cycle_count`  out  CNT_W  cycles with `core_en`=1

## Operation
- States: LOAD, PRIME, HALTED, RUN, STEP.
- Reset state is LOAD. Register reset values: `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `bp_hit`=0, `cycle_count`=0.
- Decoded outputs:
  - `load_ready` = (LOAD)
  - `core_rst` = (LOAD|PRIME)
  - `halted` = (HALTED)
  - `core_en` = STEP | (RUN & ~bp_match)
- LOAD:
  - Each handshake (`load_valid & load_ready`) registers addr/data; `imem_we`=1 in the following cycle only.
  - A handshake with `load_last`=1 moves the state to PRIME.
  - `cycle_count` and `bp_hit` clear on every entry to LOAD.
- PRIME: one cycle, `core_rst`=1, then HALTED. The last write completes during PRIME.
- HALTED:
  - Command priority is `cmd_load` > `cmd_halt` > `cmd_step` > `cmd_run`.
  - `cmd_load` goes to LOAD, `cmd_step` to STEP, `cmd_run` to RUN. `cmd_halt` stays in HALTED.
  - Entering RUN or STEP clears `bp_hit`.
- STEP: exactly one cycle with `core_en`=1, then HALTED. The breakpoint is ignored.
- RUN:
  - `core_en`=1 every cycle until `cmd_halt`, `cmd_load`, or a breakpoint match.
  - `cmd_halt` or `cmd_load` goes to HALTED. Load is only accepted from HALTED.
- bp_match = `bp_valid` & (`pc`==`bp_addr`) & ~resume.
  - resume is a 1-cycle flag set on entry to RUN. The first RUN cycle after HALTED never matches, so the host can continue past the breakpoint.
  - On a match: `core_en`=0 that cycle, so the instruction at `bp_addr` is not committed. `bp_hit` is set, then the state goes to HALTED.
- `cycle_count` increments when `core_en`=1 and saturates at all-ones.
- Outside LOAD: `load_ready`=0, and `load_valid` is ignored.

## Timing
- Command latency: a command sampled at edge N changes the state at N+1. `core_en` follows the state combinationally.
- Load write latency: a handshake at edge N produces `imem_we`=1 during cycle N+1.
- Halt: if `cmd_halt` is high in a RUN cycle, that cycle still commits (`core_en`=1); the next cycle has `core_en`=0.
- Breakpoint + `cmd_halt` in the same cycle: `core_en`=0, `bp_hit`=1, next state HALTED.
- `load_last` with `load_valid`=0: no effect.
- `load_addr` wrap and duplicate addresses are written as given, with no checking.
- `rst` mid-load: a pending write is dropped (`imem_we`=0 next cycle) and the state returns to LOAD.
- `rst` mid-run: `core_en`=0 and `core_rst`=1 from the next cycle.
- `cmd_step` held high: one STEP per visit to HALTED, so the pattern is 1 commit cycle, 1 idle cycle.

## Configuration
- Macro: `MIPS_RUN_CTRL_BP_EN`.
- Defined: breakpoint logic as described above.
- Undefined:
  - bp_match ≡ 0 and `bp_hit` is tied 0.
  - `bp_valid` and `bp_addr` stay as ports but are ignored.
  - The resume flag is not built.

## Test plan
- Reset, then load 3 words (0x0000:0x2001, 0x0001:0x2002, 0x0002:0x0000 with `load_last`):
  - 3 `imem_we` pulses, each one cycle after its handshake.
  - PRIME for 1 cycle, then `halted`=1.
  - `core_rst`=1 until HALTED.
- `cmd_step` ×4 pulses from HALTED: exactly 4 `core_en` cycles; `cycle_count`=4.
- `cmd_run` with `bp_valid`=1, `bp_addr`=0x0005, core PC advancing by 1:
  - `core_en`=0 in the cycle where `pc`=0x0005.
  - `bp_hit`=1, `halted`=1.
  - `cycle_count`=5.
- Then `cmd_run` again: the first cycle commits at `pc`=0x0005 with no re-hit, and `bp_hit` clears.
- In RUN, `cmd_halt` and a breakpoint match in the same cycle: `core_en`=0, `bp_hit`=1, HALTED next cycle.
- `rst` asserted in the middle of a load handshake:
  - `imem_we`=0 next cycle, state LOAD, `cycle_count`=0.
  - `load_valid` in RUN is never acknowledged (`load_ready`=0).

Source files
------------

// File: rtl/mips_run_ctrl.sv
// Load / run / halt / single-step sequencer for the 16-bit MIPS core.
// Optional PC breakpoint built when MIPS_RUN_CTRL_BP_EN is defined.
module mips_run_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_halt,
  input  logic              cmd_load,
  input  logic [ADDR_W-1:0] pc,
  input  logic              bp_valid,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              core_rst,
  output logic              core_en,
  output logic              halted,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_PRIME,
    S_HALTED,
    S_RUN,
    S_STEP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t             r_state;
  state_t             w_next;
  logic               r_load_ready;
  logic               r_core_rst;
  logic               r_halted;
  logic               r_imem_we;
  logic [ADDR_W-1:0]  r_imem_waddr;
  logic [DATA_W-1:0]  r_imem_wdata;
  logic [CNT_W-1:0]   r_cycle_count;
  logic               w_hs;
  logic               w_bp_match;
  logic               w_core_en;
  logic               w_to_load;
  logic               w_resume_entry;

  assign w_hs = load_valid & (r_state == S_LOAD);

`ifdef MIPS_RUN_CTRL_BP_EN
  logic r_resume;
  logic r_bp_hit;

  // The first RUN cycle after HALTED never matches so the host can
  // continue past a breakpoint it just stopped on.
  assign w_bp_match = (r_state == S_RUN) & bp_valid &
                      (pc == bp_addr) & ~r_resume;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resume <= 1'b0;
      r_bp_hit <= 1'b0;
    end else begin
      r_resume <= (r_state == S_HALTED) & (w_next == S_RUN);
      if (w_to_load | w_resume_entry) begin
        r_bp_hit <= 1'b0;
      end else if (w_bp_match) begin
        r_bp_hit <= 1'b1;
      end
    end
  end

  assign bp_hit = r_bp_hit;
`else
  logic w_unused_bp;

  assign w_unused_bp = &{1'b0, bp_valid, bp_addr};
  assign w_bp_match  = 1'b0;
  assign bp_hit      = 1'b0;
`endif

  assign w_core_en = (r_state == S_STEP) |
                     ((r_state == S_RUN) & ~w_bp_match);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD: begin
        if (w_hs & load_last) begin
          w_next = S_PRIME;
        end
      end
      S_PRIME: begin
        w_next = S_HALTED;
      end
      S_HALTED: begin
        if (cmd_load) begin
          w_next = S_LOAD;
        end else if (cmd_halt) begin
          w_next = S_HALTED;
        end else if (cmd_step) begin
          w_next = S_STEP;
        end else if (cmd_run) begin
          w_next = S_RUN;
        end
      end
      S_STEP: begin
        w_next = S_HALTED;
      end
      S_RUN: begin
        if (w_bp_match | cmd_halt | cmd_load) begin
          w_next = S_HALTED;
        end
      end
      default: begin
        w_next = S_LOAD;
      end
    endcase
  end

  assign w_to_load = (r_state == S_HALTED) & (w_next == S_LOAD);

  assign w_resume_entry = (r_state == S_HALTED) &
                          ((w_next == S_RUN) | (w_next == S_STEP));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_LOAD;
      r_load_ready  <= 1'b1;
      r_core_rst    <= 1'b1;
      r_halted      <= 1'b0;
      r_imem_we     <= 1'b0;
      r_imem_waddr  <= '0;
      r_imem_wdata  <= '0;
      r_cycle_count <= '0;
    end else begin
      r_state      <= w_next;
      r_load_ready <= (w_next == S_LOAD);
      r_core_rst   <= (w_next == S_LOAD) | (w_next == S_PRIME);
      r_halted     <= (w_next == S_HALTED);
      r_imem_we    <= w_hs;
      if (w_hs) begin
        r_imem_waddr <= load_addr;
        r_imem_wdata <= load_data;
      end
      if (w_to_load) begin
        r_cycle_count <= '0;
      end else if (w_core_en & ~(&r_cycle_count)) begin
        r_cycle_count <= r_cycle_count + CNT_ONE;
      end
    end
  end

  assign load_ready  = r_load_ready;
  assign core_rst    = r_core_rst;
  assign halted      = r_halted;
  assign core_en     = w_core_en;
  assign imem_we     = r_imem_we;
  assign imem_waddr  = r_imem_waddr;
  assign imem_wdata  = r_imem_wdata;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl against a cycle model.
// Breakpoint expectations follow MIPS_RUN_CTRL_BP_EN.
module tb_mips_run_ctrl;

`ifdef MIPS_RUN_CTRL_BP_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  localparam int L  = 0;
  localparam int P  = 1;
  localparam int H  = 2;
  localparam int R  = 3;
  localparam int S  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        imem_we;
  logic [15:0] imem_waddr;
  logic [15:0] imem_wdata;
  logic        cmd_run = 1'b0;
  logic        cmd_step = 1'b0;
  logic        cmd_halt = 1'b0;
  logic        cmd_load = 1'b0;
  logic [15:0] pc = '0;
  logic        bp_valid = 1'b0;
  logic [15:0] bp_addr = '0;
  logic        core_rst;
  logic        core_en;
  logic        halted;
  logic        bp_hit;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  mips_run_ctrl dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .load_last(load_last),
    .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .cmd_run(cmd_run), .cmd_step(cmd_step),
    .cmd_halt(cmd_halt), .cmd_load(cmd_load),
    .pc(pc), .bp_valid(bp_valid), .bp_addr(bp_addr),
    .core_rst(core_rst), .core_en(core_en),
    .halted(halted), .bp_hit(bp_hit),
    .cycle_count(cycle_count)
  );

  typedef struct {
    logic        lr;
    logic        cr;
    logic        hl;
    logic        ce;
    logic        we;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        bh;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];

  int          n_chk = 0;
  int          n_err = 0;
  int          m_st  = L;
  logic        m_we  = 1'b0;
  logic [15:0] m_wa  = '0;
  logic [15:0] m_wd  = '0;
  logic        m_bh  = 1'b0;
  logic [31:0] m_cnt = '0;
  logic        m_res = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    exp_t e;
    exp_t g;
    logic bpm;
    int   nx;
    bpm = BP && m_st == R && bp_valid &&
          pc == bp_addr && !m_res;
    e.lr  = (m_st == L);
    e.cr  = (m_st == L) || (m_st == P);
    e.hl  = (m_st == H);
    e.ce  = (m_st == S) || (m_st == R && !bpm);
    e.we  = m_we;
    e.wa  = m_wa;
    e.wd  = m_wd;
    e.bh  = m_bh;
    e.cnt = m_cnt;
    q.push_back(e);
    @(negedge clk);
    g = q.pop_front();
    chk("load_ready", 64'(load_ready), 64'(g.lr));
    chk("core_rst", 64'(core_rst), 64'(g.cr));
    chk("halted", 64'(halted), 64'(g.hl));
    chk("core_en", 64'(core_en), 64'(g.ce));
    chk("imem_we", 64'(imem_we), 64'(g.we));
    if (g.we) begin
      chk("imem_waddr", 64'(imem_waddr), 64'(g.wa));
      chk("imem_wdata", 64'(imem_wdata), 64'(g.wd));
    end
    chk("bp_hit", 64'(bp_hit), 64'(g.bh));
    chk("cycle_count", 64'(cycle_count), 64'(g.cnt));
    nx = m_st;
    case (m_st)
      L: if (load_valid && load_last) nx = P;
      P: nx = H;
      H: begin
        if (cmd_load) nx = L;
        else if (cmd_halt) nx = H;
        else if (cmd_step) nx = S;
        else if (cmd_run) nx = R;
      end
      S: nx = H;
      R: if (bpm || cmd_halt || cmd_load) nx = H;
      default: nx = L;
    endcase
    @(posedge clk);
    if (rst) begin
      m_st = L; m_we = 0; m_wa = 0; m_wd = 0;
      m_bh = 0; m_cnt = 0; m_res = 0;
      pc = 16'h0;
    end else begin
      m_we = (m_st == L) && load_valid;
      if (m_we) begin
        m_wa = load_addr;
        m_wd = load_data;
      end
      if (m_st == H && nx == L) begin
        m_cnt = 0;
        m_bh  = 0;
      end else begin
        if (g.ce && m_cnt != 32'hffff_ffff) m_cnt++;
        if (m_st == H && (nx == R || nx == S)) m_bh = 0;
        else if (bpm) m_bh = 1;
      end
      m_res = BP && m_st == H && nx == R;
      if (g.cr) pc = 16'h0;
      else if (g.ce) pc = pc + 16'h1;
      m_st = nx;
    end
    #1;
  endtask

  task automatic ld(input logic [15:0] a,
                    input logic [15:0] d,
                    input logic last);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_last  = last;
    cyc();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_run();
    cmd_run = 1'b1;
    cyc();
    cmd_run = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    load_last = 1'b1;
    cyc();
    load_last = 1'b0;
    ld(16'h0000, 16'h2001, 1'b0);
    cyc();
    ld(16'h0001, 16'h2002, 1'b0);
    ld(16'h0002, 16'h0000, 1'b1);
    cyc();
    cyc();
    chk("halted_after_prime", 64'(halted), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cmd_step = 1'b1;
      cyc();
      cmd_step = 1'b0;
      cyc();
      cyc();
    end
    chk("cnt_after_steps", 64'(cycle_count), 64'd4);
    chk("pc_after_steps", 64'(pc), 64'd4);
    bp_valid = 1'b1;
    bp_addr  = 16'h0005;
    pulse_run();
    for (int i = 0; i < 6; i++) cyc();
    cmd_halt = 1'b1;
    cyc();
    cmd_halt = 1'b0;
    cyc();
    pulse_run();
    for (int i = 0; i < 3; i++) cyc();
    cmd_halt = 1'b1;
    cyc();
    cmd_halt = 1'b0;
    cyc();
    bp_addr = pc + 16'h3;
    pulse_run();
    for (int i = 0; i < 8; i++) begin
      cmd_halt = (pc == bp_addr);
      cyc();
    end
    cmd_halt = 1'b1;
    cyc();
    cmd_halt = 1'b0;
    cyc();
    bp_valid = 1'b0;
    cmd_step = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    cmd_step = 1'b0;
    cyc();
    cmd_load = 1'b1;
    cmd_halt = 1'b1;
    cyc();
    cmd_load = 1'b0;
    cmd_halt = 1'b0;
    cyc();
    ld(16'hffff, 16'h1234, 1'b0);
    ld(16'hffff, 16'h5678, 1'b0);
    rst = 1'b1;
    ld(16'h0010, 16'habcd, 1'b0);
    rst = 1'b0;
    cyc();
    chk("rst_cnt_zero", 64'(cycle_count), 64'd0);
    ld(16'h0000, 16'h0001, 1'b1);
    cyc();
    cyc();
    pulse_run();
    load_valid = 1'b1;
    load_last  = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    load_valid = 1'b0;
    load_last  = 1'b0;
    cmd_load = 1'b1;
    cyc();
    cmd_load = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
